pwm_wave_gen: RTL and testbench

Multi-channel PWM waveform generator: a shared free-running carrier counter produces the PWM time base, and a shared envelope index advances once per carrier period. Each channel turns that index into a duty cycle according to its selected mode (square, sawtooth, triangle, inverted square) and drives a registered pulse output. It supersedes the single-channel fixed square-envelope generator with parametrised widths, multiple channels, per-channel modes, a runtime prescaler and a frame sync.

---
 rtl/pwm_wave_pkg.sv | 11 +
 rtl/pwm_wave_ch.sv | 68 ++++++
 rtl/pwm_wave_gen.sv | 70 +++++++
 tb/tb_pwm_wave_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_wave_pkg.sv
// Shared mode encoding for the multi-channel PWM waveform generator.
package pwm_wave_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE     = 2'd0,
    MODE_SAW        = 2'd1,
    MODE_TRI        = 2'd2,
    MODE_INV_SQUARE = 2'd3
  } pwm_mode_e;

endpackage

// File: rtl/pwm_wave_ch.sv
// One PWM channel: mode register, envelope-to-duty mapping and registered compare.
module pwm_wave_ch
  import pwm_wave_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int IDX_W = 6
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] count_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             wrap_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  output logic             pulse_o
);

  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

  pwm_mode_e        mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W:0]   duty;
  logic [CNT_W-1:0] saw_v, tri_v;
  logic [IDX_W-2:0] tri_t;

  // Triangle folds the upper half of the frame back down.
  assign tri_t = idx_i[IDX_W-1] ? ~idx_i[IDX_W-2:0] : idx_i[IDX_W-2:0];

  generate
    if (IDX_W >= CNT_W) begin : g_saw_trunc
      assign saw_v = idx_i[IDX_W-1 -: CNT_W];
    end else begin : g_saw_shl
      assign saw_v = {idx_i, {(CNT_W-IDX_W){1'b0}}};
    end
    if (IDX_W - 1 >= CNT_W) begin : g_tri_trunc
      assign tri_v = tri_t[IDX_W-2 -: CNT_W];
    end else begin : g_tri_shl
      assign tri_v = {tri_t, {(CNT_W-IDX_W+1){1'b0}}};
    end
  endgenerate

  always_comb begin
    mode_d = wrap_i ? pwm_mode_e'(mode_i) : mode_q;
    duty   = '0;
    case (mode_q)
      MODE_SQUARE:     duty = idx_i[IDX_W-1] ? '0 : FULL;
      MODE_SAW:        duty = {1'b0, saw_v};
      MODE_TRI:        duty = {1'b0, tri_v};
      MODE_INV_SQUARE: duty = idx_i[IDX_W-1] ? FULL : '0;
      default:         duty = '0;
    endcase
    // Duty is one bit wider than count so that FULL yields a constant high.
    pulse_d = ({1'b0, count_i} < duty) & en_i;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_SQUARE;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pwm_wave_gen.sv
// Multi-channel PWM generator: shared prescaler, carrier counter and envelope
// index driving NUM_CH independent mode/duty channels.
module pwm_wave_gen
  import pwm_wave_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int IDX_W   = 6,
  parameter int NUM_CH  = 2,
  parameter int PRESC_W = 8
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic [PRESC_W-1:0]  div,
  input  logic [NUM_CH-1:0]   enable,
  input  logic [2*NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0]   pulse,
  output logic                frame_sync
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_q, frame_d;
  logic               tick, wrap;

  always_comb begin
    // >= rather than == so a lowered div never waits for presc to roll over.
    tick    = (presc_q >= div);
    wrap    = tick & (&count_q);
    presc_d = tick ? '0 : presc_q + 1'b1;
    count_d = tick ? count_q + 1'b1 : count_q;
    idx_d   = wrap ? idx_q + 1'b1 : idx_q;
    frame_d = wrap & (&idx_q);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign frame_sync = frame_q;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pwm_wave_ch #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
      ) u_ch (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .count_i (count_q),
        .idx_i   (idx_q),
        .wrap_i  (wrap),
        .en_i    (enable[c]),
        .mode_i  (mode[2*c +: 2]),
        .pulse_o (pulse[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Directed bench for pwm_wave_gen: a cycle model feeds a scoreboard checked
// every cycle, plus directed high-time and boundary checks.
module tb_pwm_wave_gen;

  localparam int CNT_W = 6, IDX_W = 6, NUM_CH = 2, PRESC_W = 8;

  logic               sysclk = 1'b0;
  logic               rst_n;
  logic [PRESC_W-1:0] div;
  logic [NUM_CH-1:0]  enable;
  logic [2*NUM_CH-1:0] mode;
  logic [NUM_CH-1:0]  pulse;
  logic               frame_sync;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0;

  pwm_wave_gen #(
    .CNT_W(CNT_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH), .PRESC_W(PRESC_W)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .div(div), .enable(enable),
    .mode(mode), .pulse(pulse), .frame_sync(frame_sync)
  );

  always #5 sysclk = ~sysclk;

  // Reference model in plain integer arithmetic.
  int m_presc, m_count, m_idx;
  int m_mode [NUM_CH];
  bit m_tk, m_wr;
  logic [NUM_CH:0] m_e;
  logic [NUM_CH:0] sb_q [$];

  function automatic int duty_of(input int idx, input int md);
    case (md)
      0: return (idx < 32) ? 64 : 0;
      1: return idx;
      2: return (idx < 32) ? 2 * idx : 2 * (63 - idx);
      default: return (idx < 32) ? 0 : 64;
    endcase
  endfunction

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc = 0; m_count = 0; m_idx = 0;
      for (int c = 0; c < NUM_CH; c++) m_mode[c] = 0;
    end else begin
      m_tk = (m_presc >= int'(div));
      m_wr = m_tk && (m_count == 63);
      m_e[NUM_CH] = m_wr && (m_idx == 63);
      for (int c = 0; c < NUM_CH; c++)
        m_e[c] = (m_count < duty_of(m_idx, m_mode[c])) && enable[c];
      m_presc = m_tk ? 0 : m_presc + 1;
      if (m_tk) m_count = (m_count + 1) % 64;
      if (m_wr) begin
        m_idx = (m_idx + 1) % 64;
        for (int c = 0; c < NUM_CH; c++) m_mode[c] = int'(mode[2*c +: 2]);
      end
      sb_q.push_back(m_e);
    end
  end

  logic [NUM_CH:0] sb_exp;
  always @(negedge sysclk) begin
    if (rst_n && sb_q.size() > 0) begin
      sb_exp = sb_q.pop_front();
      checks++;
      assert ({frame_sync, pulse} === sb_exp) passes++;
      else begin
        fails++;
        $error("FAIL cycle_model cyc=%0d: observed %b expected %b", cyc, {frame_sync, pulse}, sb_exp);
      end
    end
  end

  task automatic step();
    @(negedge sysclk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic meas(input int ch, input int start, input int len, output int hi);
    run_to(start - 1);
    hi = 0;
    repeat (len) begin
      step();
      hi += int'(pulse[ch]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n11, n00, nfs;
    rst_n = 1'b0; div = 8'd0; enable = 2'b11; mode = 4'b0000;
    #12;
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_frame", int'(frame_sync), 0);
    step(); step();
    rst_n = 1'b1; cyc = 0;

    // Default: first half-frame full duty, second half off, one frame_sync.
    n11 = 0; n00 = 0; nfs = 0;
    for (int i = 1; i <= 4097; i++) begin
      step();
      if (i <= 2048 && pulse == 2'b11) n11++;
      if (i > 2048 && i <= 4096 && pulse == 2'b00) n00++;
      if (frame_sync) nfs++;
    end
    chk("square_high_half", n11, 2048);
    chk("square_low_half", n00, 2048);
    chk("frame_sync_once", nfs, 1);

    // Sawtooth on ch0, latched at the next carrier wrap.
    mode = 4'b0001;
    meas(0, 4161, 64, hi);  chk("saw_idx1", hi, 1);
    meas(0, 6081, 64, hi);  chk("saw_idx31", hi, 31);
    meas(0, 8129, 64, hi);  chk("saw_idx63", hi, 63);

    // Triangle on both channels.
    mode = 4'b1010;
    meas(0, 8257, 64, hi);  chk("tri_idx1", hi, 2);
    meas(0, 10177, 64, hi); chk("tri_idx31", hi, 62);
    meas(0, 10241, 64, hi); chk("tri_idx32", hi, 62);
    meas(1, 12161, 64, hi); chk("tri_idx62_ch1", hi, 2);
    meas(0, 12225, 64, hi); chk("tri_idx63", hi, 0);

    // Mode change mid-period and enable drop.
    mode = 4'b0000;
    run_to(12436);
    chk("pre_mode_change", int'(pulse), 3);
    mode = 4'b1111;
    run_to(12450);
    chk("mode_held_midperiod", int'(pulse), 3);
    enable = 2'b01;
    step();
    chk("enable_drop_next", int'(pulse), 1);
    run_to(12480);
    chk("mode_held_to_wrap", int'(pulse), 1);
    step();
    chk("inv_square_after_wrap", int'(pulse), 0);
    enable = 2'b11;
    run_to(14340);
    chk("inv_square_upper_half", int'(pulse), 3);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 20000 && !(m_idx == 40 && m_count == 17); i++) step();
    chk("reach_idx40_cnt17", m_idx * 64 + m_count, 40 * 64 + 17);
    chk("pulse_before_reset", int'(pulse), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pulse", int'(pulse), 0);
    chk("async_reset_frame", int'(frame_sync), 0);
    mode = 4'b0000; div = 8'd0;
    step(); step();
    rst_n = 1'b1; cyc = 0;
    n11 = 0;
    for (int i = 1; i <= 2049; i++) begin
      step();
      if (i <= 2048 && pulse == 2'b11) n11++;
    end
    chk("restart_high_half", n11, 2048);
    chk("restart_low_start", int'(pulse), 0);

    // Prescaler: div = 3 stretches each carrier step to 4 cycles.
    #2 rst_n = 1'b0;
    div = 8'd3; mode = 4'b0001; enable = 2'b11;
    step(); step();
    rst_n = 1'b1; cyc = 0;
    meas(1, 1, 256, hi);   chk("presc_full_period", hi, 256);
    meas(0, 257, 256, hi); chk("presc_saw_idx1", hi, 4);
    meas(0, 513, 256, hi); chk("presc_saw_idx2", hi, 8);
    run_to(771);
    chk("presc_at_3", m_presc, 3);
    div = 8'd1;
    run_to(1100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
